// File: rtl/channel_pkg.sv
// Shared types and constants for the single-token four-phase bundled-data channel.
package channel_pkg;

    localparam int DEFAULT_WIDTH = 33;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } snd_state_t;

    typedef enum logic [1:0] {
        R_EMPTY,
        R_REQ,
        R_RTZ
    } rcv_state_t;

    typedef enum logic [1:0] {
        P4PhaseBD,
        P2PhaseBD
    } hs_protocol_t;

endpackage

// File: rtl/channel_proto_check.sv
// Sticky handshake-violation monitor; only instantiated when CHANNEL_PROTO_CHECK_EN is defined.
module channel_proto_check
    import channel_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_req,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_ack,
    input  logic             armed,
    input  logic             r_ack,
    input  logic             full,
    output logic             proto_err
);

    logic             wait_q;
    logic [WIDTH-1:0] data_q;
    logic             data_viol;
    logic             drop_viol;
    logic             ack_viol;

    // wait_q: the previous edge saw an honoured request still waiting for capture
    always_comb begin
        data_viol = wait_q && s_req && !s_ack && (s_data != data_q);
        drop_viol = wait_q && !s_req && !s_ack;
        ack_viol  = !full && r_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= 1'b0;
            data_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            wait_q <= s_req && !s_ack && armed;
            data_q <= s_data;
            if (data_viol || drop_viol || ack_viol) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/channel.sv
// One-token decoupling buffer between two four-phase bundled-data handshakes.
// Optional protocol monitor enabled by defining CHANNEL_PROTO_CHECK_EN.
//   state   | meaning
//   S_IDLE  | sender side free, waiting for s_req
//   S_ACK   | s_ack high, waiting for sender return-to-zero
//   R_EMPTY | no token held
//   R_REQ   | token offered, r_req high until r_ack
//   R_RTZ   | waiting for receiver return-to-zero
module channel
    import channel_pkg::*;
#(
    parameter int           WIDTH       = DEFAULT_WIDTH,
    parameter hs_protocol_t HS_PROTOCOL = P4PhaseBD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_req,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ack,
    output logic             r_req,
    output logic [WIDTH-1:0] r_data,
    input  logic             r_ack,
    output logic             full,
    output logic             proto_err
);

    if (HS_PROTOCOL != P4PhaseBD) begin : g_bad_proto
        $error("channel: only four-phase bundled-data is supported");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("channel: WIDTH must be in 1..64");
    end

    snd_state_t snd_state;
    snd_state_t snd_nxt;
    rcv_state_t rcv_state;
    rcv_state_t rcv_nxt;
    logic       capture;
    logic       armed;

    always_comb begin
        snd_nxt = snd_state;
        rcv_nxt = rcv_state;
        // armed blocks a request that was already high when reset released
        capture = s_req && armed && (snd_state == S_IDLE) && (rcv_state == R_EMPTY);

        case (snd_state)
            S_IDLE:  if (capture) snd_nxt = S_ACK;
            S_ACK:   if (!s_req) snd_nxt = S_IDLE;
            default: snd_nxt = S_IDLE;
        endcase

        case (rcv_state)
            R_EMPTY: if (capture) rcv_nxt = R_REQ;
            R_REQ:   if (r_ack) rcv_nxt = R_RTZ;
            R_RTZ:   if (!r_ack) rcv_nxt = R_EMPTY;
            default: rcv_nxt = R_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            snd_state <= S_IDLE;
            rcv_state <= R_EMPTY;
            s_ack     <= 1'b0;
            r_req     <= 1'b0;
            full      <= 1'b0;
            armed     <= 1'b0;
            r_data    <= '0;
        end else begin
            snd_state <= snd_nxt;
            rcv_state <= rcv_nxt;
            s_ack     <= (snd_nxt == S_ACK);
            r_req     <= (rcv_nxt == R_REQ);
            full      <= (rcv_nxt != R_EMPTY);
            armed     <= armed || !s_req;
            if (capture) begin
                r_data <= s_data;
            end
        end
    end

`ifdef CHANNEL_PROTO_CHECK_EN
    channel_proto_check #(
        .WIDTH(WIDTH)
    ) u_proto_check (
        .clk      (clk),
        .rst      (rst),
        .s_req    (s_req),
        .s_data   (s_data),
        .s_ack    (s_ack),
        .armed    (armed),
        .r_ack    (r_ack),
        .full     (full),
        .proto_err(proto_err)
    );
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_channel.sv
// Directed bench for channel: handshake timing, backpressure, throughput, reset and protocol flag.
module tb_channel;
    import channel_pkg::*;

    localparam int W = 33;
`ifdef CHANNEL_PROTO_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         s_req;
    logic [W-1:0] s_data;
    logic         s_ack;
    logic         r_req;
    logic [W-1:0] r_data;
    logic         r_ack;
    logic         full;
    logic         proto_err;

    int n_checks = 0;
    int n_errors = 0;

    channel #(.WIDTH(W), .HS_PROTOCOL(P4PhaseBD)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_req    (s_req),
        .s_data   (s_data),
        .s_ack    (s_ack),
        .r_req    (r_req),
        .r_data   (r_data),
        .r_ack    (r_ack),
        .full     (full),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] TOK_A  = 33'h0_D000_0005;
    localparam logic [W-1:0] TOK_B0 = 33'h0_0000_00AA;
    localparam logic [W-1:0] TOK_B1 = 33'h1_1000_01FF;

    logic [W-1:0] rx_q[$];
    int           sender_timeouts;
    int           budget;

    initial begin
        rst = 1'b1; s_req = 1'b0; s_data = '0; r_ack = 1'b0;
        tick(); tick();
        chk_val("rst_s_ack",  64'(s_ack),  64'd0);
        chk_val("rst_r_req",  64'(r_req),  64'd0);
        chk_val("rst_full",   64'(full),   64'd0);
        chk_val("rst_r_data", 64'(r_data), 64'd0);
        chk_val("rst_err",    64'(proto_err), 64'd0);
        rst = 1'b0;
        tick();

        // single token
        s_req = 1'b1; s_data = TOK_A;
        tick();
        chk_val("t1_s_ack",  64'(s_ack),  64'd1);
        chk_val("t1_r_req",  64'(r_req),  64'd1);
        chk_val("t1_r_data", 64'(r_data), 64'(TOK_A));
        chk_val("t1_full",   64'(full),   64'd1);
        s_req = 1'b0;
        tick();
        chk_val("t1_s_ack_rtz", 64'(s_ack), 64'd0);
        chk_val("t1_r_req_hold", 64'(r_req), 64'd1);
        r_ack = 1'b1;
        tick();
        chk_val("t1_r_req_drop", 64'(r_req), 64'd0);
        chk_val("t1_full_rtz",   64'(full),  64'd1);
        r_ack = 1'b0;
        tick();
        chk_val("t1_full_clr",   64'(full),   64'd0);
        chk_val("t1_r_data_ret", 64'(r_data), 64'(TOK_A));

        // backpressure and no bypass
        s_req = 1'b1; s_data = TOK_B0;
        tick();
        chk_val("t2_first_ack", 64'(s_ack), 64'd1);
        s_req = 1'b0;
        tick();
        s_req = 1'b1; s_data = TOK_B1;
        tick();
        chk_val("t2_wait_ack0",  64'(s_ack),  64'd0);
        chk_val("t2_wait_data0", 64'(r_data), 64'(TOK_B0));
        tick();
        chk_val("t2_wait_ack1",  64'(s_ack),  64'd0);
        r_ack = 1'b1;
        tick();
        chk_val("t2_rtz_ack",    64'(s_ack),  64'd0);
        chk_val("t2_rtz_r_req",  64'(r_req),  64'd0);
        r_ack = 1'b0;
        tick();
        chk_val("t2_empty_ack",  64'(s_ack),  64'd0);
        chk_val("t2_empty_full", 64'(full),   64'd0);
        chk_val("t2_empty_data", 64'(r_data), 64'(TOK_B0));
        tick();
        chk_val("t2_cap_ack",  64'(s_ack),  64'd1);
        chk_val("t2_cap_data", 64'(r_data), 64'(TOK_B1));
        chk_val("t2_cap_full", 64'(full),   64'd1);
        s_req = 1'b0;
        tick();
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        tick();
        chk_val("t2_done_full", 64'(full), 64'd0);

        // ten tokens, immediate-ack receiver
        sender_timeouts = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    s_data = W'(i); s_req = 1'b1;
                    budget = 0;
                    do begin tick(); budget++; end while (!s_ack && budget < 50);
                    if (!s_ack) sender_timeouts++;
                    s_req = 1'b0;
                    budget = 0;
                    do begin tick(); budget++; end while (s_ack && budget < 50);
                    if (s_ack) sender_timeouts++;
                end
            end
            begin
                for (int c = 0; c < 400 && rx_q.size() < 10; c++) begin
                    tick();
                    if (r_req && !r_ack) begin
                        rx_q.push_back(r_data);
                        r_ack = 1'b1;
                    end else if (!r_req && r_ack) begin
                        r_ack = 1'b0;
                    end
                end
            end
        join
        tick();
        r_ack = 1'b0;
        tick(); tick();
        chk_val("t3_timeouts", 64'(sender_timeouts), 64'd0);
        chk_val("t3_count",    64'(rx_q.size()),     64'd10);
        for (int i = 0; i < rx_q.size(); i++)
            chk_val($sformatf("t3_tok%0d", i), 64'(rx_q[i]), 64'(i));
        chk_val("t3_err", 64'(proto_err), 64'd0);
        chk_val("t3_full", 64'(full), 64'd0);

        // reset mid-handshake, then a request held through reset
        s_req = 1'b1; s_data = 33'h0_0000_0077;
        tick();
        s_req = 1'b0;
        tick();
        s_req = 1'b1; s_data = 33'h0_0000_0033;
        rst = 1'b1;
        tick();
        chk_val("t4_rst_s_ack",  64'(s_ack),  64'd0);
        chk_val("t4_rst_r_req",  64'(r_req),  64'd0);
        chk_val("t4_rst_full",   64'(full),   64'd0);
        chk_val("t4_rst_r_data", 64'(r_data), 64'd0);
        chk_val("t4_rst_err",    64'(proto_err), 64'd0);
        rst = 1'b0;
        tick(); tick();
        chk_val("t4_held_s_ack", 64'(s_ack), 64'd0);
        chk_val("t4_held_r_req", 64'(r_req), 64'd0);
        chk_val("t4_held_full",  64'(full),  64'd0);
        s_req = 1'b0;
        tick();
        s_req = 1'b1;
        tick();
        chk_val("t4_rearm_ack",  64'(s_ack),  64'd1);
        chk_val("t4_rearm_data", 64'(r_data), 64'h33);
        chk_val("t4_err", 64'(proto_err), 64'd0);

        // payload change while waiting for capture
        s_req = 1'b0;
        tick();
        s_req = 1'b1; s_data = W'(5);
        tick();
        chk_val("t5_err_before", 64'(proto_err), 64'd0);
        s_data = W'(6);
        tick();
        chk_val("t5_err_set", 64'(proto_err), 64'(CHK_EN));
        r_ack = 1'b1;
        tick();
        r_ack = 1'b0;
        tick(); tick();
        chk_val("t5_cap_data",   64'(r_data),    64'd6);
        chk_val("t5_err_sticky", 64'(proto_err), 64'(CHK_EN));
        s_req = 1'b0;
        rst = 1'b1;
        tick();
        chk_val("t5_err_rst", 64'(proto_err), 64'd0);
        rst = 1'b0;
        tick();

        // stray receiver acknowledge while empty
        r_ack = 1'b1;
        tick();
        chk_val("t6_err",   64'(proto_err), 64'(CHK_EN));
        chk_val("t6_r_req", 64'(r_req),     64'd0);
        chk_val("t6_full",  64'(full),      64'd0);
        r_ack = 1'b0;
        tick();
        chk_val("t6_r_req_after", 64'(r_req), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
